// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: the pixel type, the unsigned max helper
// and the default frame geometry used by the convolution and pooling stages.
package cnn_pkg;

  localparam int PIX_WIDTH = 8;
  localparam int IMG_ROWS  = 540;
  localparam int IMG_COLS  = 540;

  typedef logic [PIX_WIDTH-1:0] pixel_t;

  // Unsigned maximum; on a tie either operand is the same value.
  function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_if.sv
// Pixel stream bundle between the edge-map producer and the 2x2 pooling stage.
// The master drives the input pixel stream; the slave (the pooler) drives the
// pooled output stream.
interface maxpool_2x2_if;
  import cnn_pkg::*;

  logic   in_valid;
  pixel_t in_pixel;
  logic   in_sof;
  logic   out_valid;
  pixel_t out_pixel;
  logic   out_eof;

  modport master (
    output in_valid, in_pixel, in_sof,
    input  out_valid, out_pixel, out_eof
  );

  modport slave (
    input  in_valid, in_pixel, in_sof,
    output out_valid, out_pixel, out_eof
  );

endinterface

// File: rtl/maxpool_2x2_line_buffer.sv
// Half-width row store for the pooler. Synchronous write, asynchronous read,
// no reset on the contents so it maps onto distributed RAM.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = IMG_COLS / 2,
  parameter int WIDTH  = PIX_WIDTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one horizontal max per column pair of an even row.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling of a raster-order pixel stream.
// Even rows leave one horizontal max per column pair in the line buffer;
// odd rows combine their horizontal max with it and emit one pooled pixel.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int WORD_SIZE = PIX_WIDTH,
  parameter int ROW_SIZE  = IMG_COLS,
  parameter int COL_SIZE  = IMG_ROWS
) (
  input  logic          clk,
  input  logic          rst,
  maxpool_2x2_if.slave  pool
);

  localparam int COL_W  = (ROW_SIZE > 2) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W  = (COL_SIZE > 2) ? $clog2(COL_SIZE) : 1;
  localparam int DEPTH  = ROW_SIZE / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WORD_SIZE != PIX_WIDTH) begin : g_bad_word
    $error("maxpool_2x2: WORD_SIZE must equal cnn_pkg::PIX_WIDTH");
  end
  if ((ROW_SIZE < 2) || ((ROW_SIZE % 2) != 0)) begin : g_bad_row
    $error("maxpool_2x2: ROW_SIZE must be even and at least 2");
  end
  if ((COL_SIZE < 2) || ((COL_SIZE % 2) != 0)) begin : g_bad_col
    $error("maxpool_2x2: COL_SIZE must be even and at least 2");
  end

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  pixel_t            hold;
  logic              out_valid_r;
  pixel_t            out_pixel_r;
  logic              out_eof_r;

  logic [COL_W-1:0]  eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic [COL_W-1:0]  col_next;
  logic [ROW_W-1:0]  row_next;
  logic              last_col;
  logic              last_row;
  pixel_t            hmax;
  pixel_t            lb_rd_data;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_wr_en;

  // Resolve this pixel's position (start-of-frame forces 0,0) and next counts.
  always_comb begin
    eff_col  = pool.in_sof ? {COL_W{1'b0}} : col;
    eff_row  = pool.in_sof ? {ROW_W{1'b0}} : row;
    last_col = (eff_col == COL_W'(ROW_SIZE - 1));
    last_row = (eff_row == ROW_W'(COL_SIZE - 1));
    if (last_col) begin
      col_next = {COL_W{1'b0}};
      row_next = last_row ? {ROW_W{1'b0}} : (eff_row + ROW_W'(1));
    end else begin
      col_next = eff_col + COL_W'(1);
      row_next = eff_row;
    end
    hmax     = pix_max(hold, pool.in_pixel);
    lb_addr  = ADDR_W'(eff_col >> 1);
    lb_wr_en = pool.in_valid & eff_col[0] & ~eff_row[0];
  end

  // Position counters, left-pixel hold register and registered pooled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= {COL_W{1'b0}};
      row         <= {ROW_W{1'b0}};
      hold        <= '0;
      out_valid_r <= 1'b0;
      out_pixel_r <= '0;
      out_eof_r   <= 1'b0;
    end else if (pool.in_valid) begin
      col <= col_next;
      row <= row_next;
      if (!eff_col[0]) begin
        hold        <= pool.in_pixel;
        out_valid_r <= 1'b0;
        out_eof_r   <= 1'b0;
      end else if (eff_row[0]) begin
        out_pixel_r <= pix_max(hmax, lb_rd_data);
        out_valid_r <= 1'b1;
        out_eof_r   <= last_row & last_col;
      end else begin
        out_valid_r <= 1'b0;
        out_eof_r   <= 1'b0;
      end
    end else begin
      out_valid_r <= 1'b0;
      out_eof_r   <= 1'b0;
    end
  end

  // Read and write share one address: even rows only write, odd rows only read.
  pool_line_buffer #(
    .DEPTH  (DEPTH),
    .WIDTH  (PIX_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  assign pool.out_valid = out_valid_r;
  assign pool.out_pixel = out_pixel_r;
  assign pool.out_eof   = out_eof_r;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2 on a 4x4 frame.
module tb_maxpool_2x2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  maxpool_2x2_if intf ();

  maxpool_2x2 #(
    .WORD_SIZE (8),
    .ROW_SIZE  (4),
    .COL_SIZE  (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pool (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the outputs just after the accepting edge.
  task automatic step(input logic v, input logic [7:0] p, input logic s,
                      input logic ev, input logic [7:0] ep, input logic ee,
                      input string tag);
    intf.in_valid = v;
    intf.in_pixel = p;
    intf.in_sof   = s;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'd0, intf.out_valid}, {31'd0, ev});
    chk({tag, ".eof"}, {31'd0, intf.out_eof}, {31'd0, ee});
    if (ev) chk({tag, ".pixel"}, {24'd0, intf.out_pixel}, {24'd0, ep});
  endtask

  // Pixels base+0..base+15; outputs follow pixels 5,7,13,15 (bottom-right of
  // each block, which holds the largest value of an ascending block).
  task automatic run_frame(input int base, input logic sof, input logic gaps,
                           input logic tl255, input string tag);
    logic [7:0] p;
    logic [7:0] ep;
    logic       ev;
    for (int i = 0; i < 16; i++) begin
      p = 8'(base + i);
      if (tl255 && i == 0) p = 8'd255;
      if (tl255 && (i == 1 || i == 4 || i == 5)) p = 8'd0;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      ep = (tl255 && i == 5) ? 8'd255 : 8'(base + i);
      step(1'b1, p, sof && (i == 0), ev, ep, i == 15, $sformatf("%s.px%0d", tag, i));
      if (gaps) step(1'b0, 8'hAA, 1'b1, 1'b0, 8'd0, 1'b0, $sformatf("%s.gap%0d", tag, i));
    end
  endtask

  initial begin
    intf.in_valid = 1'b0;
    intf.in_pixel = 8'd0;
    intf.in_sof   = 1'b0;

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst.valid", {31'd0, intf.out_valid}, 32'd0);
    chk("rst.pixel", {24'd0, intf.out_pixel}, 32'd0);
    chk("rst.eof", {31'd0, intf.out_eof}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, "idle0");
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, "idle1");

    // 2: gap-free frame
    run_frame(0, 1'b1, 1'b0, 1'b0, "f2");
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, "f2.tail");

    // 3: every other cycle idle (with a stray sof), 255 in the top-left block
    run_frame(0, 1'b1, 1'b1, 1'b1, "f3");

    // 4: two back-to-back frames, sof only on the first
    run_frame(0, 1'b1, 1'b0, 1'b0, "f4a");
    run_frame(16, 1'b0, 1'b0, 1'b0, "f4b");

    // 5: partial frame with large values, then a resyncing sof frame
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(200 + i), i == 0, 1'b0, 8'd0, 1'b0, $sformatf("f5.part%0d", i));
    run_frame(0, 1'b1, 1'b0, 1'b0, "f5");

    // 6: reset between edges right after an odd-row output, then frame w/o sof
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'(100 + i), i == 0, i == 5, 8'd105, 1'b0, $sformatf("f6.pre%0d", i));
    #1 rst = 1'b1;
    #1;
    chk("f6.rst.valid", {31'd0, intf.out_valid}, 32'd0);
    chk("f6.rst.pixel", {24'd0, intf.out_pixel}, 32'd0);
    chk("f6.rst.eof", {31'd0, intf.out_eof}, 32'd0);
    intf.in_valid = 1'b0;
    intf.in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, "f6.idle");
    run_frame(0, 1'b0, 1'b0, 1'b0, "f6");
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, "f6.tail");
    chk("f6.hold", {24'd0, intf.out_pixel}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
